// File: rtl/puf_measure_sequencer.sv
// Measurement sequencer for the ring-oscillator PUF: for each start request it
// walks RESP_BITS consecutive challenges. Each challenge enables one RO pair,
// clears and then gates the post-mux counters, and compares the two counts.
// The result is shifted into the response register, LSB first.
module puf_measure_sequencer #(
    parameter int CW        = 16,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 4,
    parameter int RESP_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           seed_challenge,
    input  logic [CW-1:0]        count_a,
    input  logic [CW-1:0]        count_b,
    output logic [31:0]          enable,
    output logic [7:0]           challenge,
    output logic                 cnt_clear,
    output logic                 cnt_en,
    output logic [RESP_BITS-1:0] response,
    output logic [5:0]           tie_count,
    output logic                 busy,
    output logic                 done
);

    localparam int PMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int IW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        MEASURE,
        COMPARE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] phase_cnt;
    logic [IW-1:0] bit_idx;
    logic          accept;
    logic          last_bit;
    logic          a_wins;
    logic          tie;

    // Map a challenge to its one-hot RO pair.
    // Mux A: even sel -> RO sel/2 (0..7), odd sel -> RO 16+sel/2 (16..23).
    // Mux B: even sel -> RO 24+sel/2 (24..31), odd sel -> RO 8+sel/2 (8..15).
    // The two ranges are disjoint, so exactly two bits are always set.
    function automatic logic [31:0] ro_pair(input logic [7:0] ch);
        logic [4:0] ia;
        logic [4:0] ib;
        ia = ch[0] ? {2'b10, ch[3:1]} : {2'b00, ch[3:1]};
        ib = ch[4] ? {2'b01, ch[7:5]} : {2'b11, ch[7:5]};
        return (32'd1 << ia) | (32'd1 << ib);
    endfunction

    // Next-state decode and Moore outputs.
    always_comb begin
        state_next = state;
        enable     = '0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_bit   = (bit_idx == IW'(RESP_BITS - 1));
        a_wins     = (count_a > count_b);
        tie        = (count_a == count_b);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                enable    = ro_pair(challenge);
                cnt_clear = 1'b1;
                busy      = 1'b1;
                if (phase_cnt == PW'(SETTLE - 1)) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                enable = ro_pair(challenge);
                cnt_en = 1'b1;
                busy   = 1'b1;
                if (phase_cnt == PW'(WINDOW - 1)) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                enable     = ro_pair(challenge);
                busy       = 1'b1;
                state_next = last_bit ? DONE : SETUP;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and per-phase cycle counter (restarts on every state change).
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + PW'(1);
            end
        end
    end

    // Challenge, bit index, response and tie bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            challenge <= '0;
            bit_idx   <= '0;
            response  <= '0;
            tie_count <= '0;
        end else if (accept) begin
            challenge <= seed_challenge;
            bit_idx   <= '0;
            response  <= '0;
            tie_count <= '0;
        end else if (state == COMPARE) begin
            response[bit_idx] <= a_wins;
            if (tie && (tie_count != '1)) begin
                tie_count <= tie_count + 6'd1;
            end
            if (!last_bit) begin
                bit_idx   <= bit_idx + IW'(1);
                challenge <= challenge + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_puf_measure_sequencer.sv
// Self-checking bench for puf_measure_sequencer. A behavioural pair of
// post-mux counters counts at a per-challenge rate; expected timing, RO pairs,
// responses and tie counts are derived from the seed and the rate tables.
module tb_puf_measure_sequencer;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int R   = 4;
    localparam int PER = S + W + 1;
    localparam int RUN = R * PER;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   seed_challenge = '0;
    logic [15:0]  count_a = '0;
    logic [15:0]  count_b = '0;
    logic [31:0]  enable;
    logic [7:0]   challenge;
    logic         cnt_clear;
    logic         cnt_en;
    logic [R-1:0] response;
    logic [5:0]   tie_count;
    logic         busy;
    logic         done;

    int unsigned rate_a[256];
    int unsigned rate_b[256];
    int          nb   = 0;
    int          fail = 0;
    logic [7:0]  ch_at_bit[R];
    logic [31:0] en_at_bit[R];
    int          first_done;

    puf_measure_sequencer #(
        .CW(16),
        .WINDOW(W),
        .SETTLE(S),
        .RESP_BITS(R)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .seed_challenge(seed_challenge),
        .count_a(count_a),
        .count_b(count_b),
        .enable(enable),
        .challenge(challenge),
        .cnt_clear(cnt_clear),
        .cnt_en(cnt_en),
        .response(response),
        .tie_count(tie_count),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    // Post-mux counters: clear wins over enable, rate set by the selected pair.
    always @(posedge clock) begin
        if (cnt_clear === 1'b1) begin
            count_a <= '0;
            count_b <= '0;
        end else if (cnt_en === 1'b1) begin
            count_a <= count_a + 16'(rate_a[challenge]);
            count_b <= count_b + 16'(rate_b[challenge]);
        end
    end

    function automatic logic [31:0] exp_pair(input logic [7:0] ch);
        int unsigned i;
        int unsigned j;
        int unsigned ra;
        int unsigned rb;
        i  = ch % 16;
        j  = ch / 16;
        ra = (i % 2 == 0) ? i / 2 : 16 + (i - 1) / 2;
        rb = (j % 2 == 0) ? 24 + j / 2 : 8 + (j - 1) / 2;
        return (32'd1 << ra) | (32'd1 << rb);
    endfunction

    function automatic logic [R-1:0] model_resp(input logic [7:0] seed);
        logic [R-1:0] r;
        logic [7:0]   ch;
        r = '0;
        for (int k = 0; k < R; k++) begin
            ch = 8'(seed + k);
            if (W * rate_a[ch] > W * rate_b[ch]) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [5:0] model_ties(input logic [7:0] seed);
        int         n;
        logic [7:0] ch;
        n = 0;
        for (int k = 0; k < R; k++) begin
            ch = 8'(seed + k);
            if (rate_a[ch] == rate_b[ch]) n++;
        end
        return (n > 63) ? 6'd63 : 6'(n);
    endfunction

    task automatic randomize_rates();
        for (int i = 0; i < 256; i++) begin
            rate_a[i] = $urandom_range(0, 7);
            rate_b[i] = $urandom_range(0, 7);
        end
    endtask

    // Start a run from IDLE and follow it cycle by cycle against the expected
    // timeline; ends sampling the DONE cycle. hold keeps start asserted.
    task automatic run_and_watch(input logic [7:0] seed, input bit hold);
        logic [43:0] obs;
        logic [43:0] exp_v;
        logic [7:0]  ch;
        int          k;
        int          p;
        seed_challenge = seed;
        start          = 1'b1;
        first_done     = -1;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        for (int c = 0; c <= RUN; c++) begin
            k = c / PER;
            p = c % PER;
            if (c < RUN) begin
                ch    = 8'(seed + k);
                exp_v = {exp_pair(ch), ch, (p < S), (p >= S && p < S + W), 1'b1, 1'b0};
            end else begin
                ch    = 8'(seed + R - 1);
                exp_v = {32'd0, ch, 1'b0, 1'b0, 1'b1, 1'b1};
            end
            obs = {enable, challenge, cnt_clear, cnt_en, busy, done};
            nb++;
            if (obs !== exp_v) begin
                fail++;
                $display("FAIL timeline cycle=%0d seed=%h got {en,ch,clr,cen,busy,done}=%h want %h",
                         c, seed, obs, exp_v);
            end
            if (c < RUN && p == 0) begin
                ch_at_bit[k] = challenge;
                en_at_bit[k] = enable;
            end
            if (done === 1'b1 && first_done < 0) first_done = c + 1;
            if (c < RUN) begin
                @(posedge clock); #1;
            end
        end
        // done is sampled by a consumer on the edge closing the DONE cycle
        nb++;
        if (first_done !== RUN + 1) begin
            fail++;
            $display("FAIL done_latency got %0d want %0d", first_done, RUN + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        nb++;
        if ({enable, challenge, cnt_clear, cnt_en, busy, done} !== 44'd0) begin
            fail++;
            $display("FAIL reset_ctrl got %h want 0", {enable, challenge, cnt_clear, cnt_en, busy, done});
        end
        nb++;
        if ({response, tie_count} !== '0) begin
            fail++;
            $display("FAIL reset_result got resp=%b ties=%0d want 0/0", response, tie_count);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic finish_idle(input string name, input logic [R-1:0] er, input logic [5:0] et);
        @(posedge clock); #1;
        nb++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fail++;
            $display("FAIL %s_idle got busy=%b done=%b want 0/0", name, busy, done);
        end
        nb++;
        if (response !== er || tie_count !== et) begin
            fail++;
            $display("FAIL %s_result got resp=%b ties=%0d want %b/%0d", name, response, tie_count, er, et);
        end
    endtask

    task automatic test_seed00();
        randomize_rates();
        run_and_watch(8'h00, 1'b0);
        nb++;
        if (en_at_bit[0] !== 32'h0100_0001) begin
            fail++;
            $display("FAIL seed00_enable got %h want 01000001", en_at_bit[0]);
        end
        finish_idle("seed00", model_resp(8'h00), model_ties(8'h00));
    endtask

    task automatic test_seed31();
        randomize_rates();
        rate_a[8'h31] = 13;
        rate_b[8'h31] = 11;
        run_and_watch(8'h31, 1'b0);
        nb++;
        if (en_at_bit[0] !== 32'h0001_0200) begin
            fail++;
            $display("FAIL seed31_enable got %h want 00010200", en_at_bit[0]);
        end
        nb++;
        if (response[0] !== 1'b1) begin
            fail++;
            $display("FAIL seed31_bit0 got %b want 1", response[0]);
        end
        finish_idle("seed31", model_resp(8'h31), model_ties(8'h31));
    endtask

    task automatic test_alternating();
        logic [7:0] s;
        s = 8'($urandom);
        randomize_rates();
        rate_a[8'(s)]     = 5; rate_b[8'(s)]     = 3;
        rate_a[8'(s + 1)] = 2; rate_b[8'(s + 1)] = 6;
        rate_a[8'(s + 2)] = 4; rate_b[8'(s + 2)] = 4;
        rate_a[8'(s + 3)] = 7; rate_b[8'(s + 3)] = 1;
        run_and_watch(s, 1'b0);
        nb++;
        if (response !== 4'b1001 || tie_count !== 6'd1) begin
            fail++;
            $display("FAIL alternating got resp=%b ties=%0d want 1001/1", response, tie_count);
        end
        finish_idle("alternating", 4'b1001, 6'd1);
    endtask

    task automatic test_wrap();
        randomize_rates();
        run_and_watch(8'hFE, 1'b0);
        nb++;
        if ({ch_at_bit[0], ch_at_bit[1], ch_at_bit[2], ch_at_bit[3]} !== 32'hFEFF_0001) begin
            fail++;
            $display("FAIL wrap_sequence got %h %h %h %h want FE FF 00 01",
                     ch_at_bit[0], ch_at_bit[1], ch_at_bit[2], ch_at_bit[3]);
        end
        nb++;
        if (en_at_bit[1] !== 32'h0080_8000) begin
            fail++;
            $display("FAIL wrap_enable_ff got %h want 00808000", en_at_bit[1]);
        end
        finish_idle("wrap", model_resp(8'hFE), model_ties(8'hFE));
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        s = 8'($urandom);
        randomize_rates();
        rate_a[8'(s)]     = 6; rate_b[8'(s)]     = 1;
        rate_a[8'(s + 1)] = 5; rate_b[8'(s + 1)] = 2;
        seed_challenge = s;
        start          = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // cycle 2*PER + S + 3 lies inside the measurement window of bit 2
        repeat (2 * PER + S + 3) @(posedge clock);
        #1;
        nb++;
        if (cnt_en !== 1'b1 || response[1:0] !== 2'b11) begin
            fail++;
            $display("FAIL midrun_pre got cnt_en=%b resp=%b want 1/xx11", cnt_en, response);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        nb++;
        if ({enable, cnt_en, cnt_clear, busy, done} !== 36'd0) begin
            fail++;
            $display("FAIL midrun_abort got en=%h cen=%b clr=%b busy=%b done=%b want all 0",
                     enable, cnt_en, cnt_clear, busy, done);
        end
        nb++;
        if (response !== '0 || tie_count !== 6'd0 || challenge !== 8'd0) begin
            fail++;
            $display("FAIL midrun_cleared got resp=%b ties=%0d ch=%h want 0", response, tie_count, challenge);
        end
        @(posedge clock); #1;
        s = 8'($urandom);
        randomize_rates();
        run_and_watch(s, 1'b0);
        finish_idle("after_reset", model_resp(s), model_ties(s));
    endtask

    task automatic test_start_held();
        logic [7:0]   s;
        logic [R-1:0] er;
        s = 8'($urandom);
        randomize_rates();
        er = model_resp(s);
        run_and_watch(s, 1'b1);
        nb++;
        if (response !== er) begin
            fail++;
            $display("FAIL held_done_resp got %b want %b", response, er);
        end
        finish_idle("held", er, model_ties(s));
        @(posedge clock); #1;
        nb++;
        if (busy !== 1'b1 || response !== '0 || challenge !== s) begin
            fail++;
            $display("FAIL held_reaccept got busy=%b resp=%b ch=%h want 1/0/%h", busy, response, challenge, s);
        end
        start = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_random_runs();
        logic [7:0] s;
        for (int n = 0; n < 3; n++) begin
            s = 8'($urandom);
            randomize_rates();
            run_and_watch(s, 1'b0);
            finish_idle("random", model_resp(s), model_ties(s));
        end
    endtask

    initial begin
        test_reset();
        test_seed00();
        test_seed31();
        test_alternating();
        test_wrap();
        test_reset_mid();
        test_start_held();
        test_random_runs();
        $display("End of test - %0d assertions evaluated, %0d failures", nb, fail);
        $finish;
    end

endmodule
